// File: rtl/fetch_warp_scheduler.sv
// Round-robin warp scheduler for Fetch: up to two one-hot grants per cycle.
// Define FETCH_DUAL_ISSUE_EN for the second grant port; otherwise it is tied to 0.
module fetch_warp_scheduler #(
   parameter int NUM_WARPS  = 8,
   parameter int CREDIT_MAX = 2,
   parameter int FETCH_LAT  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_WARPS-1:0] Warp_Active_IF,
   input  logic [NUM_WARPS-1:0] Credit_Return_IB_IF,
   input  logic [NUM_WARPS-1:0] Flush_IF,
   input  logic                 Stall_IF,
   output logic [NUM_WARPS-1:0] GRT_raw_1_RR_IF,
   output logic [NUM_WARPS-1:0] GRT_raw_2_RR_IF,
   output logic                 Credit_Err
);

   localparam int CW = $clog2(CREDIT_MAX + 1);
   localparam int LW = $clog2(FETCH_LAT + 1);
   localparam int PW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

   localparam logic [CW-1:0] CRED_FULL = CW'(CREDIT_MAX);
   localparam logic [LW-1:0] LOCK_LOAD = LW'(FETCH_LAT);
   localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_WARPS - 1);

   logic [PW-1:0]        ptr_q, ptr_d;
   logic [CW-1:0]        credit_q [NUM_WARPS];
   logic [CW-1:0]        credit_d [NUM_WARPS];
   logic [LW-1:0]        lock_q   [NUM_WARPS];
   logic [LW-1:0]        lock_d   [NUM_WARPS];
   logic [NUM_WARPS-1:0] grt1_q, grt1_d;
   logic [NUM_WARPS-1:0] grt2_q, grt2_d;
   logic                 err_q, err_d;

   logic [NUM_WARPS-1:0] elig;
   logic                 g1_vld, g2_vld;
   logic [PW-1:0]        g1_idx, g2_idx;
   logic [PW-1:0]        scan;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
      return (i == LAST_IDX) ? '0 : i + 1'b1;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_WARPS; i++) begin
         elig[i] = Warp_Active_IF[i] & (credit_q[i] != '0)
                 & (lock_q[i] == '0) & ~Flush_IF[i] & ~Stall_IF;
      end
   end

   always_comb begin
      g1_vld = 1'b0;
      g1_idx = '0;
      g2_vld = 1'b0;
      g2_idx = '0;
      scan   = '0;
      for (int k = 0; k < NUM_WARPS; k++) begin
         scan = PW'((int'(ptr_q) + k) % NUM_WARPS);
         if (!g1_vld && elig[scan]) begin
            g1_vld = 1'b1;
            g1_idx = scan;
         end
      end
`ifdef FETCH_DUAL_ISSUE_EN
      // second port keeps scanning past the first winner
      for (int k = 1; k < NUM_WARPS; k++) begin
         scan = PW'((int'(g1_idx) + k) % NUM_WARPS);
         if (g1_vld && !g2_vld && elig[scan]) begin
            g2_vld = 1'b1;
            g2_idx = scan;
         end
      end
`endif
   end

   always_comb begin
      grt1_d = '0;
      grt2_d = '0;
      if (g1_vld) grt1_d[g1_idx] = 1'b1;
      if (g2_vld) grt2_d[g2_idx] = 1'b1;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (g2_vld)      ptr_d = wrap_inc(g2_idx);
      else if (g1_vld) ptr_d = wrap_inc(g1_idx);
   end

   always_comb begin
      err_d = err_q;
      for (int i = 0; i < NUM_WARPS; i++) begin
         credit_d[i] = credit_q[i];
         lock_d[i]   = lock_q[i];
         if (Flush_IF[i]) begin
            credit_d[i] = CRED_FULL;
            lock_d[i]   = '0;
         end else begin
            if (grt1_d[i] | grt2_d[i])  lock_d[i] = LOCK_LOAD;
            else if (lock_q[i] != '0)   lock_d[i] = lock_q[i] - 1'b1;
            unique case ({grt1_d[i] | grt2_d[i], Credit_Return_IB_IF[i]})
               2'b10: credit_d[i] = credit_q[i] - 1'b1;
               2'b01: begin
                  if (credit_q[i] == CRED_FULL) err_d = 1'b1;
                  else credit_d[i] = credit_q[i] + 1'b1;
               end
               default: credit_d[i] = credit_q[i];
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q  <= '0;
         grt1_q <= '0;
         grt2_q <= '0;
         err_q  <= 1'b0;
         for (int i = 0; i < NUM_WARPS; i++) begin
            credit_q[i] <= CRED_FULL;
            lock_q[i]   <= '0;
         end
      end else begin
         ptr_q  <= ptr_d;
         grt1_q <= grt1_d;
         grt2_q <= grt2_d;
         err_q  <= err_d;
         for (int i = 0; i < NUM_WARPS; i++) begin
            credit_q[i] <= credit_d[i];
            lock_q[i]   <= lock_d[i];
         end
      end
   end

   assign GRT_raw_1_RR_IF = grt1_q;
`ifdef FETCH_DUAL_ISSUE_EN
   assign GRT_raw_2_RR_IF = grt2_q;
`else
   assign GRT_raw_2_RR_IF = '0;
`endif
   assign Credit_Err = err_q;

endmodule
